bus_response_encoder: RTL and testbench

Sits directly downstream of the logic analyzer core's output bus port, at the end of the core chain. It consumes read-response transactions (16-bit data, rw=0) and serialises each one into a 7-byte ASCII message: 'M', four uppercase hex digits, CR, LF. The bytes go to the host UART transmitter over a valid/ready byte handshake. Write acknowledgements (rw=1) are consumed silently.

---
 rtl/bus_response_encoder_pkg.sv | 19 +
 rtl/bus_response_encoder_hex.sv | 23 ++
 rtl/bus_response_encoder.sv | 136 +++++++++++++
 tb/tb_bus_response_encoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_response_encoder_pkg.sv
// Shared types and ASCII constants for the bus response encoder and later bridge encoders.
package bus_response_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int MSG_LEN = 7;
  localparam int IDX_W   = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_M    = 8'h4D;

endpackage

// File: rtl/bus_response_encoder_hex.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_nibble_to_ascii
  import bus_response_encoder_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [7:0] unused_pad,
  output logic [7:0] ascii
);

  logic [7:0] nibble_ext;
  logic       unused_ok;

  assign nibble_ext = {4'h0, nibble};
  assign unused_ok  = ^unused_pad;

  always_comb begin
    ascii = ASCII_ZERO + nibble_ext;
    if (nibble_ext >= 8'd10) begin
      ascii = ASCII_A + (nibble_ext - 8'd10);
    end
  end

endmodule

// File: rtl/bus_response_encoder.sv
// Serialises 16-bit read responses into "M" + 4 hex digits + CR LF over a byte valid/ready link.
module bus_response_encoder
  import bus_response_encoder_pkg::*;
#(
  parameter logic [7:0] PREAMBLE = ASCII_M,
  parameter logic [7:0] EOL_CR   = ASCII_CR,
  parameter logic [7:0] EOL_LF   = ASCII_LF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        overflow_o
);

  state_t           state, state_nxt;
  logic [15:0]      cur_data, cur_nxt;
  logic [15:0]      pend_data, pend_data_nxt;
  logic             pend_valid, pend_valid_nxt;
  logic             ovf, ovf_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             incoming, accept, done;
  logic [3:0]       nibble;
  logic [7:0]       nibble_char;

  assign incoming = valid_i & ~rw_i;
  assign accept   = (state == SEND) & tx_ready_i;
  assign done     = accept & (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_data   <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      ovf        <= 1'b0;
      idx        <= '0;
    end else begin
      state      <= state_nxt;
      cur_data   <= cur_nxt;
      pend_data  <= pend_data_nxt;
      pend_valid <= pend_valid_nxt;
      ovf        <= ovf_nxt;
      idx        <= idx_nxt;
    end
  end

  // On completion the pending word is promoted first so a same-cycle arrival can refill the slot.
  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur_data;
    pend_data_nxt  = pend_data;
    pend_valid_nxt = pend_valid;
    ovf_nxt        = ovf;
    idx_nxt        = idx;
    case (state)
      IDLE: begin
        if (incoming) begin
          cur_nxt   = data_i;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          idx_nxt = idx + 3'd1;
        end
        if (done) begin
          idx_nxt = '0;
          if (pend_valid) begin
            cur_nxt        = pend_data;
            pend_valid_nxt = incoming;
            if (incoming) begin
              pend_data_nxt = data_i;
            end
          end else if (incoming) begin
            cur_nxt = data_i;
          end else begin
            state_nxt = IDLE;
          end
        end else if (incoming) begin
          if (!pend_valid) begin
            pend_valid_nxt = 1'b1;
            pend_data_nxt  = data_i;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    nibble = 4'h0;
    case (idx)
      3'd1:    nibble = cur_data[15:12];
      3'd2:    nibble = cur_data[11:8];
      3'd3:    nibble = cur_data[7:4];
      3'd4:    nibble = cur_data[3:0];
      default: nibble = 4'h0;
    endcase
  end

  // The address is carried only so every core in the chain shares one port shape.
  hex_nibble_to_ascii u_hex (
    .nibble     (nibble),
    .unused_pad (addr_i[7:0] ^ addr_i[15:8]),
    .ascii      (nibble_char)
  );

  always_comb begin
    tx_data_o = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:             tx_data_o = PREAMBLE;
        3'd1, 3'd2,
        3'd3, 3'd4:       tx_data_o = nibble_char;
        3'd5:             tx_data_o = EOL_CR;
        3'd6:             tx_data_o = EOL_LF;
        default:          tx_data_o = 8'h00;
      endcase
    end
  end

  assign tx_valid_o = (state == SEND);
  assign busy_o     = (state == SEND) | pend_valid;
  assign overflow_o = ovf;

endmodule

// File: tb/tb_bus_response_encoder.sv
// Self-checking bench: directed scenarios plus random traffic against a message-queue reference model.
module tb_bus_response_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] addr_i;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        overflow_o;

  int vectors;
  int miscompares;

  // Reference model: words still owed to the host (front is being sent), progress in the front word.
  logic [15:0] mq[$];
  int          mcnt;
  logic        movf;

  logic [7:0] txlog[$];

  logic [7:0] m1234 [7] = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
  logic [7:0] mabcf [7] = '{8'h4D, 8'h41, 8'h42, 8'h43, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] m0009 [7] = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
  logic [7:0] m00ff [7] = '{8'h4D, 8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] m1111 [7] = '{8'h4D, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] m2222 [7] = '{8'h4D, 8'h32, 8'h32, 8'h32, 8'h32, 8'h0D, 8'h0A};
  logic [7:0] m0001 [7] = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};

  bus_response_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_byte(input logic [15:0] w, input int k);
    int n;
    if (k == 0) return 8'h4D;
    if (k == 5) return 8'h0D;
    if (k == 6) return 8'h0A;
    n = (int'(w) >> (4 * (4 - k))) & 15;
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic compareAll();
    logic       exp_valid;
    logic [7:0] exp_data;
    exp_valid = (mq.size() > 0);
    exp_data  = exp_valid ? ref_byte(mq[0], mcnt) : 8'h00;
    checkOutput("tx_valid", {15'h0, tx_valid_o}, {15'h0, exp_valid});
    checkOutput("tx_data", {8'h0, tx_data_o}, {8'h0, exp_data});
    checkOutput("busy", {15'h0, busy_o}, {15'h0, exp_valid});
    checkOutput("overflow", {15'h0, overflow_o}, {15'h0, movf});
  endtask

  task automatic modelUpdate(input logic r, input logic v, input logic w,
                             input logic [15:0] d, input logic rdy);
    if (r) begin
      mq.delete();
      mcnt = 0;
      movf = 1'b0;
    end else begin
      if (mq.size() > 0 && rdy) begin
        mcnt++;
        if (mcnt == 7) begin
          void'(mq.pop_front());
          mcnt = 0;
        end
      end
      if (v && !w) begin
        if (mq.size() < 2) mq.push_back(d);
        else movf = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs at the negedge, advance the model at the posedge, compare at the next negedge.
  task automatic applyStimulus(input logic r, input logic v, input logic w,
                               input logic [15:0] d, input logic rdy);
    rst        = r;
    valid_i    = v;
    rw_i       = w;
    data_i     = d;
    tx_ready_i = rdy;
    addr_i     = 16'($urandom);
    #1;
    if (!r && tx_valid_o && rdy) txlog.push_back(tx_data_o);
    @(posedge clk);
    modelUpdate(r, v, w, d, rdy);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, rdy);
  endtask

  task automatic checkMsg(input string tag, input int off, input logic [7:0] e[7]);
    logic [15:0] obs;
    for (int i = 0; i < 7; i++) begin
      obs = (off + i < txlog.size()) ? {8'h0, txlog[off + i]} : 16'hFFFF;
      checkOutput(tag, obs, {8'h0, e[i]});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mcnt        = 0;
    movf        = 1'b0;
    rst         = 1'b1;
    valid_i     = 1'b0;
    rw_i        = 1'b0;
    data_i      = 16'h0000;
    addr_i      = 16'h0000;
    tx_ready_i  = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("reset_tx_valid", {15'h0, tx_valid_o}, 16'h0000);
    checkOutput("reset_tx_data", {8'h0, tx_data_o}, 16'h0000);

    $display("[TB] single reads");
    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 1'b1);
    checkOutput("latency_first_byte", {8'h0, tx_data_o}, 16'h004D);
    idleCycles(10, 1'b1);
    checkMsg("msg_1234", 0, m1234);
    checkOutput("len_1234", 16'(txlog.size()), 16'd7);

    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hABCF, 1'b1);
    idleCycles(9, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0009, 1'b1);
    idleCycles(9, 1'b1);
    checkMsg("msg_abcf", 0, mabcf);
    checkMsg("msg_0009", 7, m0009);

    $display("[TB] write ignored");
    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    idleCycles(20, 1'b1);
    checkOutput("write_no_bytes", 16'(txlog.size()), 16'd0);

    $display("[TB] backpressure");
    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FF, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, (i % 3) == 0);
    checkMsg("msg_00ff_bp", 0, m00ff);
    checkOutput("len_00ff_bp", 16'(txlog.size()), 16'd7);

    $display("[TB] overflow");
    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h2222, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h3333, 1'b1);
    checkOutput("overflow_set", {15'h0, overflow_o}, 16'h0001);
    idleCycles(16, 1'b1);
    checkMsg("msg_1111", 0, m1111);
    checkMsg("msg_2222", 7, m2222);
    checkOutput("len_overflow", 16'(txlog.size()), 16'd14);
    checkOutput("overflow_sticky", {15'h0, overflow_o}, 16'h0001);

    $display("[TB] reset mid-message");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b1);
    idleCycles(4, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("midrst_tx_valid", {15'h0, tx_valid_o}, 16'h0000);
    checkOutput("midrst_busy", {15'h0, busy_o}, 16'h0000);
    checkOutput("midrst_overflow", {15'h0, overflow_o}, 16'h0000);
    txlog.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 1'b1);
    idleCycles(10, 1'b1);
    checkMsg("msg_0001", 0, m0001);
    checkOutput("len_0001", 16'(txlog.size()), 16'd7);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 249) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0,
                    16'($urandom),
                    $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
